word_packer_256: RTL and testbench
==================================

// Module: word_packer_256
// PURPOSE
//  Packs a stream of 16-bit words into one 256-bit result vector. This is the
//  write-side counterpart of the 16:1 word-select mux (muxdiv): word k lands in
//  result[16k+15:16k], so muxdiv sel=k reads back the k-th accepted word. Sits
//  between the serial producer and the wide consumer that feeds muxdiv.
// PARAMETERS
//  WORD_W   16   width of one input word, in bits
//  NWORDS   16   words per packed result; result width = WORD_W*NWORDS = 256
//  IDX_W    4    slot index width, $clog2(NWORDS)
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-high reset
//  in_valid   in   1    in_word is valid this cycle
//  in_ready   out  1    packer accepts a word this cycle
//  in_word    in   16   input word
//  flush      in   1    close a partial result early
//  out_valid  out  1    result is complete and stable
//  out_ready  in   1    consumer takes the result this cycle
//  result     out  256  packed vector; slot k = result[16k+15:16k]
//  count      out  5    number of slots written, 0..16
// BEHAVIOUR
//  - Reset (async, any state): state=FILL, idx=0, result=0, count=0,
//    out_valid=0. in_ready=1 once reset deasserts.
//  - in_ready = (state==FILL). out_valid = (state==FULL). Both are registered
//    state decodes; neither depends combinationally on in_valid or out_ready.
//  - FILL: on in_valid&in_ready, write in_word into slot idx, then idx+=1 and
//    count+=1. Writing slot 15 moves to FULL on the next edge; idx wraps to 0.
//  - flush in FILL with count>0: go to FULL. Unwritten slots stay 0.
//  - flush and an accept in the same cycle: the word is written first, then
//    go to FULL.
//  - flush with count==0 and no accept: ignored; stays in FILL.
//  - FULL: result and count are held stable and in_valid is ignored. On
//    out_ready, the next edge goes to FILL with idx=0, count=0, result=0.
//    New words are accepted from the following cycle (one bubble cycle).
//  - flush in FULL: ignored.
//  - Latency: the 16th accepted word gives out_valid=1 on the next cycle.
//  - Slots are written only at their own index; no shifting.
//  - Reset mid-fill or while FULL discards the partial or complete result.
// TESTING
//  1. reset, then 16 words 0x0000..0x000F back-to-back -> out_valid one cycle
//     after the last word; result[16k+15:16k]==k; count==16; in_ready==0.
//  2. Hold out_ready=0 for 10 cycles with in_valid=1 -> result unchanged and
//     no words consumed. Pulse out_ready -> FILL next cycle with result==0.
//  3. 3 words 0xAAAA,0xBBBB,0xCCCC, then flush -> result[47:0]==0xCCCCBBBBAAAA,
//     upper bits 0, count==3.
//  4. flush with count==0 -> out_valid stays 0. Flush on the same cycle as the
//     5th word -> count==5 and slot 4 is present.
//  5. Assert reset asynchronously after 7 words -> result==0 and count==0 at
//     once; a full 16-word pack after that is correct.
//  6. Random in_valid/out_ready gaps over 100 packets vs a reference model;
//     each slot matches the muxdiv readback at sel=k.

Source files
------------

// File: rtl/word_packer_256.sv
// Packs a stream of WORD_W-bit words into one NWORDS*WORD_W-bit result.
// Word k lands in result[WORD_W*k +: WORD_W]; a flush closes a partial result early.
module word_packer_256 #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16,
  parameter int IDX_W  = $clog2(NWORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_word,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] result,
  output logic [IDX_W:0]           count
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W:0]             count_q, count_d;
  logic [WORD_W*NWORDS-1:0]   result_q, result_d;
  logic                       accept;
  logic                       clear;

  assign accept = (state_q == FILL) && in_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    clear   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          idx_d   = idx_q + 1'b1;
          count_d = count_q + 1'b1;
          // The word is stored before a same-cycle flush closes the result.
          if (idx_q == IDX_W'(NWORDS - 1) || flush) state_d = FULL;
        end else if (flush && count_q != '0) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          count_d = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Each slot is written only at its own index; no data ever moves between slots.
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
      logic slot_we;
      assign slot_we = accept && (idx_q == IDX_W'(gi));
      assign result_d[gi*WORD_W +: WORD_W] =
        clear   ? '0      :
        slot_we ? in_word : result_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      idx_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign result    = result_q;
  assign count     = count_q;

endmodule

// File: tb/tb_word_packer_256.sv
// Randomised and directed bench for word_packer_256 against a queue-based packet model.
module tb_word_packer_256;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_word;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] result;
  logic [4:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the words of the current packet, and whether the packet is closed.
  bit          m_full;
  logic [15:0] m_q[$];

  word_packer_256 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] m_result();
    logic [255:0] r = '0;
    foreach (m_q[k]) r[k*16 +: 16] = m_q[k];
    return r;
  endfunction

  function automatic logic [15:0] muxdiv(input logic [255:0] v, input int sel);
    return v[sel*16 +: 16];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_in_ready"},  256'(in_ready),  256'(!m_full));
    chk({tag, "_out_valid"}, 256'(out_valid), 256'(m_full));
    chk({tag, "_count"},     256'(count),     256'(m_q.size()));
    chk({tag, "_result"},    result,          m_result());
  endtask

  // Called at a negedge: drives inputs for the next posedge, advances the model, checks after it.
  task automatic step(input string tag, input bit v, input logic [15:0] w,
                      input bit fl, input bit ordy);
    in_valid  = v;
    in_word   = w;
    flush     = fl;
    out_ready = ordy;
    if (!m_full) begin
      if (v) begin
        m_q.push_back(w);
        if (m_q.size() == 16 || fl) m_full = 1'b1;
      end else if (fl && m_q.size() > 0) begin
        m_full = 1'b1;
      end
    end else if (ordy) begin
      m_q.delete();
      m_full = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int packets;
    int cycles;
    bit v, fl, ordy, drained;

    reset = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; out_ready = 1'b0;
    m_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("reset");

    // 1: sixteen back-to-back words
    for (int k = 0; k < 16; k++) step("t1", 1'b1, 16'(k), 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) chk("t1_slot", 256'(muxdiv(result, k)), 256'(k));
    chk("t1_count", 256'(count), 256'd16);
    chk("t1_in_ready", 256'(in_ready), 256'd0);
    $display("t1 full pack: count=%0d out_valid=%0b", count, out_valid);

    // 2: consumer stall while producer keeps offering words
    for (int k = 0; k < 10; k++) step("t2_hold", 1'b1, 16'($urandom), 1'b0, 1'b0);
    step("t2_drain", 1'b1, 16'h1234, 1'b0, 1'b1);
    chk("t2_cleared", result, 256'd0);
    $display("t2 stall/drain: in_ready=%0b count=%0d", in_ready, count);

    // 3: partial packet closed by flush
    step("t3", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    step("t3", 1'b1, 16'hBBBB, 1'b0, 1'b0);
    step("t3", 1'b1, 16'hCCCC, 1'b0, 1'b0);
    step("t3_flush", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t3_low", 256'(result[47:0]), 256'h0000CCCCBBBBAAAA);
    chk("t3_high", 256'(result[255:48]), 256'd0);
    chk("t3_count", 256'(count), 256'd3);
    $display("t3 flush partial: count=%0d", count);
    step("t3_drain", 1'b0, 16'h0, 1'b0, 1'b1);

    // 4: empty flush is ignored; flush together with the fifth word
    step("t4_empty_flush", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t4_no_valid", 256'(out_valid), 256'd0);
    for (int k = 0; k < 4; k++) step("t4", 1'b1, 16'h4000 + 16'(k), 1'b0, 1'b0);
    step("t4_flush_word", 1'b1, 16'h5555, 1'b1, 1'b0);
    chk("t4_count", 256'(count), 256'd5);
    chk("t4_slot4", 256'(muxdiv(result, 4)), 256'h5555);
    step("t4_full_flush", 1'b0, 16'h0, 1'b1, 1'b0);
    $display("t4 flush with word: count=%0d slot4=%0h", count, muxdiv(result, 4));
    step("t4_drain", 1'b0, 16'h0, 1'b0, 1'b1);

    // 5: asynchronous reset mid-fill
    for (int k = 0; k < 7; k++) step("t5", 1'b1, 16'h7000 + 16'(k), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_async_result", result, 256'd0);
    chk("t5_async_count", 256'(count), 256'd0);
    m_q.delete();
    m_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("t5_after_reset");
    for (int k = 0; k < 16; k++) step("t5_pack", 1'b1, 16'($urandom), 1'b0, 1'b0);
    $display("t5 reset then pack: out_valid=%0b count=%0d", out_valid, count);
    step("t5_drain", 1'b0, 16'h0, 1'b0, 1'b1);

    // 6: random traffic, 100 packets
    packets = 0;
    cycles  = 0;
    while (packets < 100 && cycles < 20000) begin
      v       = ($urandom_range(0, 9) < 7);
      fl      = ($urandom_range(0, 19) == 0);
      ordy    = $urandom_range(0, 1) == 1;
      drained = m_full && ordy;
      if (drained) begin
        for (int k = 0; k < 16; k++)
          chk("t6_slot", 256'(muxdiv(result, k)), 256'(k < m_q.size() ? m_q[k] : 16'h0));
        $display("t6 packet %0d: %0d words", packets, m_q.size());
      end
      step("t6", v, 16'($urandom), fl, ordy);
      if (drained) packets++;
      cycles++;
    end
    if (packets < 100) chk("t6_budget", 256'(packets), 256'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
